apb_rr_arbiter: RTL and testbench
=================================

// Module: apb_rr_arbiter
// PURPOSE
//  Shares one APB master port among NREQ local requesters using round-robin arbitration.
//  Each requester posts a single read or write (addr/wdata/write).
//  The block grants one requester, runs the APB SETUP/ACCESS phases, and returns rdata/err
//  to the granted requester. Sits between DMA/CPU-side clients and the APB slave fabric.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  16  max ACCESS cycles waiting for pready_i; 0 disables timeout
// PORTS
//  pclk_i       in   1        APB clock
//  prst_n       in   1        async active-low reset
//  req_valid_i  in   NREQ     request pending, one bit per requester
//  req_write_i  in   NREQ     1=write, 0=read, per requester
//  req_addr_i   in   NREQ*AW  packed addresses; requester i at [i*AW +: AW]
//  req_wdata_i  in   NREQ*DW  packed write data; requester i at [i*DW +: DW]
//  req_ready_o  out  NREQ     one-hot 1-cycle accept pulse
//  rsp_valid_o  out  NREQ     one-hot 1-cycle completion pulse
//  rsp_rdata_o  out  DW       read data (0 for writes); valid with rsp_valid_o
//  rsp_err_o    out  1        pslverr_i or timeout; valid with rsp_valid_o
//  psel_o, penable_o, pwrite_o  out  1   APB controls
//  paddr_o      out  AW       APB address
//  pwdata_o     out  DW       APB write data
//  prdata_i     in   DW       APB read data
//  pready_i     in   1        APB ready
//  pslverr_i    in   1        APB slave error
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=NREQ-1 (requester 0 has first priority); timeout cnt=0.
//  FSM states: IDLE -> SETUP -> ACCESS.
//   IDLE:   if any req_valid_i, grant -> SETUP; else stay.
//   SETUP:  psel=1, penable=0; always -> ACCESS next cycle.
//   ACCESS: psel=1, penable=1; holds until pready_i=1 or timeout.
//           On completion: if any req_valid_i, grant -> SETUP (no idle gap); else -> IDLE.
//  Grant (cycle T, in IDLE or completing ACCESS):
//   - Winner = first set req_valid_i scanning upward from ptr+1, wrapping.
//   - req_ready_o[winner]=1 combinationally in T.
//   - addr/wdata/write/index registered at T; ptr<=winner.
//   - Requester may change its fields after T.
//   - A requester that completes in T is not blocked from re-requesting; rr handles fairness.
//  APB outputs:
//   - paddr/pwdata/pwrite come from command regs, stable from SETUP through ACCESS end.
//   - pwdata=0 for reads.
//   - Outside SETUP/ACCESS, psel=penable=0; paddr/pwdata/pwrite hold last value.
//  Latency: grant T -> psel T+1 -> penable T+2 -> earliest completion edge end of T+2.
//   - rsp_valid_o[idx] pulses in T+3 (registered), with rsp_rdata_o and rsp_err_o.
//  Response data:
//   - rsp_rdata_o = prdata_i sampled at completion for reads; 0 for writes.
//   - rsp_rdata_o holds until the next rsp_valid.
//   - rsp_err_o = pslverr_i sampled at completion.
//  Timeout (TIMEOUT>0):
//   - Counter clears on entering ACCESS and increments each ACCESS cycle with pready_i=0.
//   - When cnt==TIMEOUT-1 and pready_i=0, transfer ends: rsp_err_o=1, rsp_rdata_o=0.
//   - psel/penable drop as on normal completion.
//  Simultaneous pready_i and timeout: pready_i wins (normal completion).
//  req_valid_i deasserted before grant: request is dropped silently (no response).
//  Async reset mid-transfer: psel/penable drop immediately.
//   - No rsp_valid is issued for the aborted transfer; requester must re-issue.
//  Never more than one outstanding APB transfer.
// TESTING
//  1 Single read: req0 valid, addr=0xDEADCAFE, pready=1 in first ACCESS, prdata=0x12345678
//    -> ready0 at T, psel T+1, penable T+2, rsp_valid0 at T+3, rdata=0x12345678, err=0.
//  2 Round-robin: all 4 requesters held valid continuously
//    -> grant order 0,1,2,3,0,1; back-to-back SETUP after each ACCESS, no IDLE cycle.
//  3 Wait states + error: write from req2, pready low 3 cycles, then pready=1, pslverr=1
//    -> penable high 4 cycles, pwdata stable, rsp_valid2 with err=1, rdata=0.
//  4 Timeout: TIMEOUT=16, pready held 0
//    -> ACCESS lasts exactly 16 cycles, rsp_err=1, rdata=0; FSM then IDLE.
//  5 Reset mid-ACCESS: assert prst_n low during a req1 read
//    -> psel/penable=0 asynchronously, no rsp_valid; after release, req0 and req1 valid -> req0 granted first.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//   Shares one APB master port among NREQ local requesters using round-robin
//   arbitration. Each requester posts a single read or write; the winner's
//   command is captured, driven through the APB SETUP/ACCESS phases, and the
//   response (rdata/err) is returned to that requester as a one-cycle pulse.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   AW / DW  address / data width
//   TIMEOUT  max ACCESS cycles waiting for pready_i; 0 disables the timeout
//
// Ports
//   pclk_i, prst_n             APB clock, asynchronous active-low reset
//   req_valid_i/req_write_i    per-requester request and direction
//   req_addr_i/req_wdata_i     packed per-requester address / write data
//   req_ready_o                one-hot accept pulse (combinational, grant cycle)
//   rsp_valid_o                one-hot completion pulse (registered)
//   rsp_rdata_o/rsp_err_o      response data / error, valid with rsp_valid_o
//   psel_o/penable_o/pwrite_o  APB controls
//   paddr_o/pwdata_o           APB address / write data
//   prdata_i/pready_i/pslverr_i APB slave response
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk_i,
  input  logic               prst_n,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ-1:0]    req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [AW-1:0]      paddr_o,
  output logic [DW-1:0]      pwdata_o,
  input  logic [DW-1:0]      prdata_i,
  input  logic               pready_i,
  input  logic               pslverr_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_write;
  logic [CW-1:0]   r_cnt;
  logic            r_psel;
  logic            r_penable;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic            w_timeout;
  logic            w_done;
  logic            w_grant;
  logic [NREQ-1:0] w_idx_onehot;

  // Round-robin winner: scan downward so the lowest offset from ptr+1 wins last.
  always_comb begin
    logic [IW-1:0] w_cand;
    w_found  = |req_valid_i;
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand   = IW'((int'(r_ptr) + k) % NREQ);
      w_winner = req_valid_i[w_cand] ? w_cand : w_winner;
    end
  end

  // Transfer completion and grant qualification; pready_i has priority over timeout.
  always_comb begin
    w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_LAST) && !pready_i;
    w_done    = (r_state == ST_ACCESS) && (pready_i || w_timeout);
    w_grant   = w_found && ((r_state == ST_IDLE) || w_done);
  end

  // One-hot decodes for the accept pulse and the captured requester index.
  always_comb begin
    req_ready_o  = {NREQ{1'b0}};
    w_idx_onehot = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i]  = w_grant && (w_winner == IW'(i));
      w_idx_onehot[i] = (r_idx == IW'(i));
    end
  end

  // Next-state logic for the IDLE/SETUP/ACCESS sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_next_state = ST_SETUP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done) begin
          w_next_state = w_grant ? ST_SETUP : ST_IDLE;
        end else begin
          w_next_state = ST_ACCESS;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register with APB controls registered from the next state.
  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_psel    <= (w_next_state != ST_IDLE);
      r_penable <= (w_next_state == ST_ACCESS);
    end
  end

  // Command capture at grant; write data is zeroed for reads so pwdata reads 0.
  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      r_ptr   <= IW'(NREQ - 1);
      r_idx   <= {IW{1'b0}};
      r_addr  <= {AW{1'b0}};
      r_wdata <= {DW{1'b0}};
      r_write <= 1'b0;
    end else if (w_grant) begin
      r_ptr   <= w_winner;
      r_idx   <= w_winner;
      r_addr  <= req_addr_i[int'(w_winner)*AW +: AW];
      r_wdata <= req_write_i[w_winner] ? req_wdata_i[int'(w_winner)*DW +: DW] : {DW{1'b0}};
      r_write <= req_write_i[w_winner];
    end
  end

  // Wait-state counter: cleared while in SETUP so it starts at 0 in ACCESS.
  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_state == ST_SETUP) begin
      r_cnt <= {CW{1'b0}};
    end else if ((r_state == ST_ACCESS) && !pready_i) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Response capture; rdata holds between completions, a timeout reports err with 0 data.
  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      r_rsp_valid <= {NREQ{1'b0}};
      r_rsp_rdata <= {DW{1'b0}};
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= w_idx_onehot;
      r_rsp_rdata <= (pready_i && !r_write) ? prdata_i : {DW{1'b0}};
      r_rsp_err   <= pready_i ? pslverr_i : 1'b1;
    end else begin
      r_rsp_valid <= {NREQ{1'b0}};
    end
  end

  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_write;
  assign paddr_o     = r_addr;
  assign pwdata_o    = r_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_arbiter
//   Self-checking bench for apb_rr_arbiter (NREQ=4, AW=DW=32, TIMEOUT=16).
//   A vector table drives single transfers with varying wait states; a
//   scoreboard queue holds expected responses that a monitor pops on each
//   rsp_valid pulse. Hand-written sequences cover round-robin order and
//   reset during ACCESS.
// -----------------------------------------------------------------------------
module tb_apb_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic               pclk_i = 1'b0;
  logic               prst_n;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_write_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_wdata_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [DW-1:0]      rsp_rdata_o;
  logic               rsp_err_o;
  logic               psel_o;
  logic               penable_o;
  logic               pwrite_o;
  logic [AW-1:0]      paddr_o;
  logic [DW-1:0]      pwdata_o;
  logic [DW-1:0]      prdata_i;
  logic               pready_i;
  logic               pslverr_i;

  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .pclk_i      (pclk_i),
    .prst_n      (prst_n),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;   // ACCESS cycles with pready low; >= TO means timeout
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every completion pulse must match the oldest expectation.
  always @(negedge pclk_i) begin
    if (prst_n === 1'b1 && rsp_valid_o !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_idx", 32'(rsp_valid_o), 32'(oh(mon_e.idx)));
        chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
      end
    end
  end

  // Runs one table vector from an idle arbiter; called at a falling edge.
  task automatic run_vec(input vec_t v);
    int          n_acc;
    logic [31:0] exp_pwdata;
    exp_pwdata = v.wr ? v.wdata : 32'h0;
    n_acc      = (v.waits < TO) ? v.waits + 1 : TO;
    req_write_i[v.idx]           = v.wr;
    req_addr_i[v.idx*AW +: AW]   = v.addr;
    req_wdata_i[v.idx*DW +: DW]  = v.wdata;
    req_valid_i                  = oh(v.idx);
    #1;
    chk("grant_ready", 32'(req_ready_o), 32'(oh(v.idx)));
    sb.push_back('{v.idx, v.exp_rdata, v.exp_err});
    @(negedge pclk_i);
    req_valid_i                  = 4'b0000;
    req_addr_i[v.idx*AW +: AW]   = ~v.addr;
    req_wdata_i[v.idx*DW +: DW]  = ~v.wdata;
    req_write_i[v.idx]           = ~v.wr;
    chk("setup_phase", 32'({psel_o, penable_o}), 32'd2);
    chk("setup_paddr", paddr_o, v.addr);
    chk("setup_pwrite", 32'(pwrite_o), 32'(v.wr));
    chk("setup_pwdata", pwdata_o, exp_pwdata);
    for (int c = 0; c < n_acc; c++) begin
      @(negedge pclk_i);
      chk("access_phase", 32'({psel_o, penable_o}), 32'd3);
      chk("access_pwdata", pwdata_o, exp_pwdata);
      chk("access_paddr", paddr_o, v.addr);
      pready_i  = (c == v.waits);
      prdata_i  = v.prdata;
      pslverr_i = v.slverr;
    end
    @(negedge pclk_i);
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = 32'h0;
    chk("rsp_latency", 32'(rsp_valid_o), 32'(oh(v.idx)));
    chk("back_to_idle", 32'({psel_o, penable_o}), 32'd0);
    @(negedge pclk_i);
    chk("rsp_single_pulse", 32'(rsp_valid_o), 32'd0);
    chk("rdata_hold", rsp_rdata_o, v.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int last_cyc;

    vecs[0] = '{0, 1'b0, 32'hDEADCAFE, 32'h00000000, 0,  32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h00000100, 32'hA5A55A5A, 3,  32'hFFFF0000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{3, 1'b0, 32'h00000200, 32'h11112222, 1,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h00000300, 32'h00000000, 16, 32'h0BAD0BAD, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{1, 1'b1, 32'h00000400, 32'h77778888, 0,  32'h99999999, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{3, 1'b0, 32'h00000500, 32'h00000000, 15, 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0};

    prst_n      = 1'b0;
    req_valid_i = 4'b0000;
    req_write_i = 4'b0000;
    req_addr_i  = '0;
    req_wdata_i = '0;
    prdata_i    = 32'h0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    #12;
    chk("rst_apb_ctl", 32'({psel_o, penable_o, pwrite_o}), 32'd0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    @(negedge pclk_i);
    prst_n = 1'b1;
    @(negedge pclk_i);

    // Round-robin: all requesters held valid, pready always high.
    for (int i = 0; i < NREQ; i++) req_addr_i[i*AW +: AW] = 32'h1000 + 32'(i);
    prdata_i    = 32'h5A5A0001;
    pready_i    = 1'b1;
    req_valid_i = 4'b1111;
    gcnt        = 0;
    last_cyc    = 0;
    for (int cyc = 0; cyc < 40 && gcnt < 6; cyc++) begin
      #1;
      if (req_ready_o != 4'b0000) begin
        chk("rr_order", 32'(req_ready_o), 32'(oh(gcnt % 4)));
        if (gcnt > 0) chk("rr_no_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        sb.push_back('{gcnt % 4, 32'h5A5A0001, 1'b0});
        gcnt++;
      end
      @(negedge pclk_i);
    end
    req_valid_i = 4'b0000;
    chk("rr_grant_count", 32'(gcnt), 32'd6);
    repeat (4) @(negedge pclk_i);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    chk("rr_idle", 32'({psel_o, penable_o}), 32'd0);
    @(negedge pclk_i);

    // Table-driven single transfers: latency, wait states, error, timeout.
    for (int n = 0; n < 6; n++) begin
      run_vec(vecs[n]);
    end

    // Reset during ACCESS of a req1 read.
    req_write_i[1]           = 1'b0;
    req_addr_i[1*AW +: AW]   = 32'h00000600;
    req_valid_i              = 4'b0010;
    #1;
    chk("rst_seq_ready1", 32'(req_ready_o), 32'd2);
    @(negedge pclk_i);
    req_valid_i = 4'b0000;
    @(negedge pclk_i);
    @(negedge pclk_i);
    chk("rst_seq_in_access", 32'({psel_o, penable_o}), 32'd3);
    #2;
    prst_n = 1'b0;
    #1;
    chk("rst_seq_async_drop", 32'({psel_o, penable_o}), 32'd0);
    chk("rst_seq_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(negedge pclk_i);
    @(negedge pclk_i);
    prst_n                   = 1'b1;
    req_write_i[0]           = 1'b0;
    req_addr_i[0*AW +: AW]   = 32'h00000700;
    req_valid_i              = 4'b0011;
    #1;
    chk("rst_seq_req0_first", 32'(req_ready_o), 32'd1);
    sb.push_back('{0, 32'h2468ACE0, 1'b0});
    @(negedge pclk_i);
    req_valid_i = 4'b0000;
    chk("rst_seq_paddr", paddr_o, 32'h00000700);
    @(negedge pclk_i);
    pready_i = 1'b1;
    prdata_i = 32'h2468ACE0;
    @(negedge pclk_i);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    chk("rst_seq_rsp0", 32'(rsp_valid_o), 32'd1);
    repeat (3) @(negedge pclk_i);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
